// File: rtl/cci_mpf_shim_vtp_svc_mux_pkg.sv
// rtl/cci_mpf_shim_vtp_svc_mux_pkg.sv - shared VTP typedefs for the translation service mux
package cci_mpf_shim_vtp_svc_mux_pkg;

    localparam int CCI_PT_VA_BITS = 48;
    localparam int CCI_PT_PA_BITS = 48;
    localparam int CCI_PT_4KB_PAGE_OFFSET_BITS = 12;

    localparam int VA_IDX_BITS = CCI_PT_VA_BITS - CCI_PT_4KB_PAGE_OFFSET_BITS;
    localparam int PA_IDX_BITS = CCI_PT_PA_BITS - CCI_PT_4KB_PAGE_OFFSET_BITS;

    typedef logic [VA_IDX_BITS-1:0] t_tlb_4kb_va_page_idx;
    typedef logic [PA_IDX_BITS-1:0] t_tlb_4kb_pa_page_idx;

    localparam int MUX_N_TAGS_DEFAULT = 16;

    typedef logic [$clog2(MUX_N_TAGS_DEFAULT)-1:0] t_mux_tag_idx;

    // Server-side request/response layouts; field order matches the flat port packing.
    typedef struct packed {
        t_tlb_4kb_va_page_idx pageVA;
        t_mux_tag_idx         tag;
    } t_mux_srv_req;

    typedef struct packed {
        t_tlb_4kb_pa_page_idx pagePA;
        t_mux_tag_idx         tag;
        logic                 isBigPage;
    } t_mux_srv_rsp;

    // Index width that stays legal for a single-entry collection.
    function automatic int mux_idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cci_mpf_shim_vtp_tag_pool.sv
// rtl/cci_mpf_shim_vtp_tag_pool.sv - server tag pool: busy bitmap, lowest-free encoder, count
module cci_mpf_shim_vtp_tag_pool
    import cci_mpf_shim_vtp_svc_mux_pkg::*;
#(
    parameter int N_TAGS = MUX_N_TAGS_DEFAULT,
    localparam int TAG_BITS = $clog2(N_TAGS)
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                allocEn,
    input  logic                freeEn,
    input  logic [TAG_BITS-1:0] freeTag,
    output logic [TAG_BITS-1:0] allocTag,
    output logic                notFull,
    output logic [N_TAGS-1:0]   tagBusy,
    output logic [TAG_BITS:0]   numBusy
);

    logic [N_TAGS-1:0] allocMask;
    logic [N_TAGS-1:0] freeMask;

    // Descending scan so the lowest free index is the last one written.
    always_comb begin
        allocTag = '0;
        for (int i = N_TAGS - 1; i >= 0; i--) begin
            if (!tagBusy[i]) allocTag = TAG_BITS'(i);
        end
    end

    assign notFull   = ~&tagBusy;
    assign allocMask = allocEn ? ({{(N_TAGS-1){1'b0}}, 1'b1} << allocTag) : '0;
    assign freeMask  = freeEn  ? ({{(N_TAGS-1){1'b0}}, 1'b1} << freeTag)  : '0;

    // Allocation always targets a free tag and release a busy one, so the masks never overlap.
    always_ff @(posedge clk) begin
        if (reset) begin
            tagBusy <= '0;
            numBusy <= '0;
        end else begin
            tagBusy <= (tagBusy | allocMask) & ~freeMask;
            if (allocEn && !freeEn) begin
                numBusy <= numBusy + 1'b1;
            end else if (!allocEn && freeEn) begin
                numBusy <= numBusy - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cci_mpf_shim_vtp_svc_mux.sv
// rtl/cci_mpf_shim_vtp_svc_mux.sv - round-robin mux of client VTP lookups onto one tagged server port
module cci_mpf_shim_vtp_svc_mux
    import cci_mpf_shim_vtp_svc_mux_pkg::*;
#(
    parameter int N_CLIENTS = 2,
    parameter int N_TAGS = MUX_N_TAGS_DEFAULT,
    parameter int CLIENT_TAG_BITS = 4,
    localparam int TAG_BITS = $clog2(N_TAGS),
    localparam int CLIENT_IDX_BITS = mux_idx_bits(N_CLIENTS)
)
(
    input  logic                                        clk,
    input  logic                                        reset,

    input  logic [N_CLIENTS-1:0]                        c_lookupEn,
    input  logic [N_CLIENTS-1:0][VA_IDX_BITS-1:0]       c_pageVA,
    input  logic [N_CLIENTS-1:0][CLIENT_TAG_BITS-1:0]   c_tag,
    output logic [N_CLIENTS-1:0]                        c_lookupRdy,
    output logic [N_CLIENTS-1:0]                        c_rspValid,
    output logic [PA_IDX_BITS+CLIENT_TAG_BITS:0]        c_rsp,

    output logic                                        s_lookupEn,
    output logic [VA_IDX_BITS+TAG_BITS-1:0]             s_lookupReq,
    input  logic                                        s_lookupRdy,
    input  logic                                        s_lookupRspValid,
    input  logic [PA_IDX_BITS+TAG_BITS:0]               s_lookupRsp,

    output logic [TAG_BITS:0]                           numOutstanding,
    output logic                                        errBadTag
);

    function automatic logic [CLIENT_IDX_BITS-1:0] rr_client(
        input logic [CLIENT_IDX_BITS-1:0] base,
        input int                         offset
    );
        return CLIENT_IDX_BITS'((int'(base) + offset) % N_CLIENTS);
    endfunction

    logic [CLIENT_IDX_BITS-1:0] rrPtr;
    logic [CLIENT_IDX_BITS-1:0] grantIdx;
    logic                       grantValid;
    logic                       anyReq;
    logic                       canGrant;

    logic                       outValid;
    logic [VA_IDX_BITS-1:0]     outVA;
    logic [TAG_BITS-1:0]        outTag;

    logic [TAG_BITS-1:0]        allocTag;
    logic                       poolNotFull;
    logic [N_TAGS-1:0]          tagBusy;

    logic [PA_IDX_BITS-1:0]     rspPA;
    logic [TAG_BITS-1:0]        rspTag;
    logic                       rspBig;
    logic                       rspHit;

    logic [CLIENT_IDX_BITS+CLIENT_TAG_BITS-1:0] tagTable [N_TAGS];
    logic [CLIENT_IDX_BITS+CLIENT_TAG_BITS-1:0] tableRd;

    logic                       rspValidQ;
    logic [CLIENT_IDX_BITS-1:0] rspClientQ;
    logic [CLIENT_TAG_BITS-1:0] rspClientTagQ;
    logic [PA_IDX_BITS-1:0]     rspPAQ;
    logic                       rspBigQ;

    // The output slot is reusable in the same cycle the server takes its current request.
    assign canGrant = !reset && (!outValid || s_lookupRdy) && poolNotFull;

    // Highest-priority requester is the first one found walking forward from rrPtr.
    always_comb begin
        anyReq   = 1'b0;
        grantIdx = '0;
        for (int k = N_CLIENTS - 1; k >= 0; k--) begin
            if (c_lookupEn[rr_client(rrPtr, k)]) begin
                anyReq   = 1'b1;
                grantIdx = rr_client(rrPtr, k);
            end
        end
        grantValid = anyReq && canGrant;
    end

    always_comb begin
        c_lookupRdy = '0;
        if (grantValid) c_lookupRdy[grantIdx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rrPtr <= '0;
        end else if (grantValid) begin
            rrPtr <= rr_client(grantIdx, 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outValid <= 1'b0;
        end else if (grantValid) begin
            outValid <= 1'b1;
            outVA    <= c_pageVA[grantIdx];
            outTag   <= allocTag;
        end else if (s_lookupRdy) begin
            outValid <= 1'b0;
        end
    end

    assign s_lookupEn  = outValid && !reset;
    assign s_lookupReq = {outVA, outTag};

    cci_mpf_shim_vtp_tag_pool #(
        .N_TAGS   (N_TAGS)
    ) tagPool (
        .clk      (clk),
        .reset    (reset),
        .allocEn  (grantValid),
        .freeEn   (rspHit),
        .freeTag  (rspTag),
        .allocTag (allocTag),
        .notFull  (poolNotFull),
        .tagBusy  (tagBusy),
        .numBusy  (numOutstanding)
    );

    always_ff @(posedge clk) begin
        if (grantValid) begin
            tagTable[allocTag] <= {grantIdx, c_tag[grantIdx]};
        end
    end

    assign rspPA   = s_lookupRsp[PA_IDX_BITS+TAG_BITS:TAG_BITS+1];
    assign rspTag  = s_lookupRsp[TAG_BITS:1];
    assign rspBig  = s_lookupRsp[0];
    assign rspHit  = s_lookupRspValid && tagBusy[rspTag];
    assign tableRd = tagTable[rspTag];

    // Responses naming an unallocated tag only raise the sticky error; nothing is routed or freed.
    always_ff @(posedge clk) begin
        if (reset) begin
            rspValidQ <= 1'b0;
            errBadTag <= 1'b0;
        end else begin
            rspValidQ <= rspHit;
            if (s_lookupRspValid && !tagBusy[rspTag]) errBadTag <= 1'b1;
        end
        rspClientQ    <= tableRd[CLIENT_IDX_BITS+CLIENT_TAG_BITS-1:CLIENT_TAG_BITS];
        rspClientTagQ <= tableRd[CLIENT_TAG_BITS-1:0];
        rspPAQ        <= rspPA;
        rspBigQ       <= rspBig;
    end

    always_comb begin
        c_rspValid = '0;
        if (rspValidQ) c_rspValid[rspClientQ] = 1'b1;
    end

    assign c_rsp = {rspPAQ, rspClientTagQ, rspBigQ};

endmodule

// File: tb/tb_cci_mpf_shim_vtp_svc_mux.sv
// tb/tb_cci_mpf_shim_vtp_svc_mux.sv - self-checking bench for cci_mpf_shim_vtp_svc_mux
module tb_cci_mpf_shim_vtp_svc_mux;

    localparam int NC = 2;
    localparam int NT = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NC-1:0]         c_lookupEn;
    logic [NC-1:0][35:0]   c_pageVA;
    logic [NC-1:0][3:0]    c_tag;
    logic [NC-1:0]         c_lookupRdy;
    logic [NC-1:0]         c_rspValid;
    logic [40:0]           c_rsp;
    logic                  s_lookupEn;
    logic [39:0]           s_lookupReq;
    logic                  s_lookupRdy;
    logic                  s_lookupRspValid;
    logic [40:0]           s_lookupRsp;
    logic [4:0]            numOutstanding;
    logic                  errBadTag;

    int total = 0;
    int bad = 0;

    // Reference model: which tags are in use and by whom, the server slot, and the expected response.
    bit          mBusy [NT];
    int          mClient [NT];
    logic [3:0]  mCTag [NT];
    int          mPtr;
    bit          mOutV;
    logic [35:0] mOutVA;
    int          mOutTag;
    bit          mRspV;
    int          mRspClient;
    logic [3:0]  mRspCTag;
    logic [35:0] mRspPA;
    logic        mRspBig;
    bit          mErr;
    int          srvIssued[$];

    always #5 clk = ~clk;

    cci_mpf_shim_vtp_svc_mux #(
        .N_CLIENTS        (NC),
        .N_TAGS           (NT),
        .CLIENT_TAG_BITS  (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .c_lookupEn       (c_lookupEn),
        .c_pageVA         (c_pageVA),
        .c_tag            (c_tag),
        .c_lookupRdy      (c_lookupRdy),
        .c_rspValid       (c_rspValid),
        .c_rsp            (c_rsp),
        .s_lookupEn       (s_lookupEn),
        .s_lookupReq      (s_lookupReq),
        .s_lookupRdy      (s_lookupRdy),
        .s_lookupRspValid (s_lookupRspValid),
        .s_lookupRsp      (s_lookupRsp),
        .numOutstanding   (numOutstanding),
        .errBadTag        (errBadTag)
    );

    function automatic logic [35:0] rnd36();
        return 36'({$urandom(), $urandom()});
    endfunction

    task automatic idle();
        c_lookupEn       = '0;
        s_lookupRdy      = 1'b1;
        s_lookupRspValid = 1'b0;
        s_lookupRsp      = '0;
    endtask

    task automatic respond_tag(input int tag, input logic [35:0] pa, input logic big);
        int idx;
        s_lookupRspValid = 1'b1;
        s_lookupRsp      = {pa, 4'(tag), big};
        idx = -1;
        for (int i = 0; i < srvIssued.size(); i++) begin
            if (idx < 0 && srvIssued[i] == tag) idx = i;
        end
        if (idx >= 0) srvIssued.delete(idx);
    endtask

    // One clock: at the falling edge compare DUT against the model, then advance the model.
    task automatic tick();
        int cnt, g, alloc, t, c;
        logic [NC-1:0] expRdy, expRsp;
        @(negedge clk);
        if (reset) begin
            total++;
            if (c_lookupRdy !== '0 || s_lookupEn !== 1'b0) begin
                bad++;
                $display("FAIL mon_reset_gating rdy=%b en=%b want rdy=00 en=0", c_lookupRdy, s_lookupEn);
            end
            @(posedge clk);
            foreach (mBusy[i]) mBusy[i] = 1'b0;
            mOutV = 0; mPtr = 0; mErr = 0; mRspV = 0;
            srvIssued.delete();
            #1;
            return;
        end
        cnt = 0;
        foreach (mBusy[i]) cnt += int'(mBusy[i]);
        total++;
        if (s_lookupEn !== mOutV) begin
            bad++; $display("FAIL mon_s_lookupEn got=%b want=%b t=%0t", s_lookupEn, mOutV, $time);
        end
        if (mOutV) begin
            total++;
            if (s_lookupReq !== {mOutVA, 4'(mOutTag)}) begin
                bad++; $display("FAIL mon_s_lookupReq got=%h want=%h t=%0t", s_lookupReq, {mOutVA, 4'(mOutTag)}, $time);
            end
        end
        expRsp = mRspV ? (NC'(1) << mRspClient) : '0;
        total++;
        if (c_rspValid !== expRsp) begin
            bad++; $display("FAIL mon_c_rspValid got=%b want=%b t=%0t", c_rspValid, expRsp, $time);
        end
        if (mRspV) begin
            total++;
            if (c_rsp !== {mRspPA, mRspCTag, mRspBig}) begin
                bad++; $display("FAIL mon_c_rsp got=%h want=%h t=%0t", c_rsp, {mRspPA, mRspCTag, mRspBig}, $time);
            end
        end
        total++;
        if (numOutstanding !== 5'(cnt)) begin
            bad++; $display("FAIL mon_numOutstanding got=%0d want=%0d t=%0t", numOutstanding, cnt, $time);
        end
        total++;
        if (errBadTag !== mErr) begin
            bad++; $display("FAIL mon_errBadTag got=%b want=%b t=%0t", errBadTag, mErr, $time);
        end
        g = -1;
        if ((!mOutV || s_lookupRdy) && cnt < NT) begin
            for (int k = 0; k < NC; k++) begin
                c = (mPtr + k) % NC;
                if (g < 0 && c_lookupEn[c]) g = c;
            end
        end
        expRdy = (g >= 0) ? (NC'(1) << g) : '0;
        total++;
        if (c_lookupRdy !== expRdy) begin
            bad++; $display("FAIL mon_c_lookupRdy got=%b want=%b t=%0t", c_lookupRdy, expRdy, $time);
        end
        alloc = -1;
        for (int i = 0; i < NT; i++) if (alloc < 0 && !mBusy[i]) alloc = i;
        if (mOutV && s_lookupRdy) srvIssued.push_back(mOutTag);
        mRspV = 0;
        if (s_lookupRspValid) begin
            t = int'(s_lookupRsp[4:1]);
            if (mBusy[t]) begin
                mRspV = 1; mRspClient = mClient[t]; mRspCTag = mCTag[t];
                mRspPA = s_lookupRsp[40:5]; mRspBig = s_lookupRsp[0];
                mBusy[t] = 0;
            end else begin
                mErr = 1;
            end
        end
        if (g >= 0) begin
            mBusy[alloc] = 1; mClient[alloc] = g; mCTag[alloc] = c_tag[g];
            mOutV = 1; mOutVA = c_pageVA[g]; mOutTag = alloc;
            mPtr = (g + 1) % NC;
        end else if (s_lookupRdy) begin
            mOutV = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            idle();
            if (srvIssued.size() == 0 && numOutstanding == 0 && !s_lookupEn) break;
            if (srvIssued.size() > 0) respond_tag(srvIssued[0], rnd36(), 1'($urandom));
            tick();
        end
        idle();
        total++;
        if (numOutstanding !== 5'd0) begin
            bad++; $display("FAIL drain_outstanding got=%0d want=0", numOutstanding);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        c_lookupEn = '1;
        #1;
        total++;
        if (c_lookupRdy !== '0 || s_lookupEn !== 1'b0) begin
            bad++; $display("FAIL reset_outputs rdy=%b en=%b want 00/0", c_lookupRdy, s_lookupEn);
        end
        tick();
        tick();
        reset = 1'b0;
        c_lookupEn = '0;
        #1;
        total++;
        if (numOutstanding !== 5'd0 || s_lookupEn !== 1'b0 || c_rspValid !== '0 || errBadTag !== 1'b0) begin
            bad++; $display("FAIL reset_state num=%0d en=%b rspV=%b err=%b want 0/0/00/0",
                            numOutstanding, s_lookupEn, c_rspValid, errBadTag);
        end
        tick();
    endtask

    task automatic test_single();
        idle();
        c_lookupEn = 2'b10; c_pageVA[1] = 36'h12345; c_tag[1] = 4'd3;
        #1;
        total++;
        if (c_lookupRdy !== 2'b10) begin bad++; $display("FAIL single_grant got=%b want=10", c_lookupRdy); end
        tick();
        idle();
        #1;
        total++;
        if (s_lookupEn !== 1'b1 || s_lookupReq !== {36'h12345, 4'd0}) begin
            bad++; $display("FAIL single_srv_req en=%b req=%h want 1/%h", s_lookupEn, s_lookupReq, {36'h12345, 4'd0});
        end
        tick();
        respond_tag(0, 36'h0ABCD, 1'b0);
        #1;
        total++;
        if (c_rspValid !== 2'b00) begin bad++; $display("FAIL single_early_rsp got=%b want=00", c_rspValid); end
        tick();
        idle();
        #1;
        total++;
        if (c_rspValid !== 2'b10 || c_rsp !== {36'h0ABCD, 4'd3, 1'b0}) begin
            bad++; $display("FAIL single_rsp v=%b rsp=%h want 10/%h", c_rspValid, c_rsp, {36'h0ABCD, 4'd3, 1'b0});
        end
        tick();
    endtask

    task automatic test_fairness();
        int n0, n1, prev, cur, d;
        n0 = 0; n1 = 0; prev = -1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            idle();
            c_lookupEn = 2'b11;
            c_pageVA[0] = rnd36(); c_pageVA[1] = rnd36();
            c_tag[0] = 4'($urandom); c_tag[1] = 4'($urandom);
            if (srvIssued.size() > 0) respond_tag(srvIssued[0], rnd36(), 1'($urandom));
            #1;
            cur = (c_lookupRdy === 2'b01) ? 0 : (c_lookupRdy === 2'b10) ? 1 : -1;
            total++;
            if (cur < 0 || cur == prev) begin
                bad++; $display("FAIL fair_alternate cyc=%0d rdy=%b prev=%0d", cyc, c_lookupRdy, prev);
            end
            if (cur == 0) n0++;
            if (cur == 1) n1++;
            prev = cur;
            tick();
        end
        d = n0 - n1;
        total++;
        if (d > 1 || d < -1 || n0 + n1 != 100) begin
            bad++; $display("FAIL fair_counts n0=%0d n1=%0d want equal within 1, sum 100", n0, n1);
        end
        drain();
    endtask

    task automatic test_pool_full();
        logic [35:0] va5;
        do_reset();
        for (int i = 0; i < NT; i++) begin
            idle();
            c_lookupEn = 2'b01; c_pageVA[0] = rnd36(); c_tag[0] = 4'(i);
            #1;
            total++;
            if (c_lookupRdy !== 2'b01) begin bad++; $display("FAIL full_fill_grant i=%0d got=%b want=01", i, c_lookupRdy); end
            tick();
        end
        idle();
        c_lookupEn = 2'b11;
        #1;
        total++;
        if (numOutstanding !== 5'd16 || c_lookupRdy !== 2'b00) begin
            bad++; $display("FAIL full_block num=%0d rdy=%b want 16/00", numOutstanding, c_lookupRdy);
        end
        tick();
        respond_tag(5, rnd36(), 1'b1);
        #1;
        total++;
        if (c_lookupRdy !== 2'b00) begin bad++; $display("FAIL full_rsp_cycle rdy=%b want=00", c_lookupRdy); end
        tick();
        idle();
        va5 = rnd36();
        c_lookupEn = 2'b11; c_pageVA[1] = va5;
        #1;
        total++;
        if (numOutstanding !== 5'd15 || c_lookupRdy !== 2'b10) begin
            bad++; $display("FAIL full_resume num=%0d rdy=%b want 15/10", numOutstanding, c_lookupRdy);
        end
        tick();
        idle();
        #1;
        total++;
        if (s_lookupEn !== 1'b1 || s_lookupReq !== {va5, 4'd5}) begin
            bad++; $display("FAIL full_reuse_tag5 req=%h want=%h", s_lookupReq, {va5, 4'd5});
        end
        tick();
        drain();
    endtask

    task automatic test_server_stall();
        logic [35:0] va0;
        idle();
        va0 = rnd36();
        s_lookupRdy = 1'b0; c_lookupEn = 2'b01; c_pageVA[0] = va0;
        #1;
        total++;
        if (c_lookupRdy !== 2'b01) begin bad++; $display("FAIL stall_first_grant got=%b want=01", c_lookupRdy); end
        tick();
        for (int i = 0; i < 10; i++) begin
            idle();
            s_lookupRdy = 1'b0; c_lookupEn = 2'b11;
            c_pageVA[0] = rnd36(); c_pageVA[1] = rnd36();
            #1;
            total++;
            if (s_lookupEn !== 1'b1 || s_lookupReq !== {va0, 4'd0} || c_lookupRdy !== 2'b00 || numOutstanding !== 5'd1) begin
                bad++; $display("FAIL stall_hold i=%0d en=%b req=%h rdy=%b num=%0d want 1/%h/00/1",
                                i, s_lookupEn, s_lookupReq, c_lookupRdy, numOutstanding, {va0, 4'd0});
            end
            tick();
        end
        idle();
        tick();
        drain();
    endtask

    task automatic test_ooo_badtag();
        logic [35:0] pa [3];
        do_reset();
        foreach (pa[i]) pa[i] = rnd36();
        idle(); c_lookupEn = 2'b01; c_tag[0] = 4'hA; c_pageVA[0] = rnd36(); tick();
        idle(); c_lookupEn = 2'b10; c_tag[1] = 4'h5; c_pageVA[1] = rnd36(); tick();
        idle(); c_lookupEn = 2'b01; c_tag[0] = 4'hC; c_pageVA[0] = rnd36(); tick();
        idle(); tick();
        idle(); respond_tag(2, pa[2], 1'b1); tick();
        idle(); respond_tag(0, pa[0], 1'b0);
        #1;
        total++;
        if (c_rspValid !== 2'b01 || c_rsp !== {pa[2], 4'hC, 1'b1}) begin
            bad++; $display("FAIL ooo_tag2 v=%b rsp=%h want 01/%h", c_rspValid, c_rsp, {pa[2], 4'hC, 1'b1});
        end
        tick();
        idle(); respond_tag(1, pa[1], 1'b0);
        #1;
        total++;
        if (c_rspValid !== 2'b01 || c_rsp !== {pa[0], 4'hA, 1'b0}) begin
            bad++; $display("FAIL ooo_tag0 v=%b rsp=%h want 01/%h", c_rspValid, c_rsp, {pa[0], 4'hA, 1'b0});
        end
        tick();
        idle(); respond_tag(7, rnd36(), 1'b0);
        #1;
        total++;
        if (c_rspValid !== 2'b10 || c_rsp !== {pa[1], 4'h5, 1'b0}) begin
            bad++; $display("FAIL ooo_tag1 v=%b rsp=%h want 10/%h", c_rspValid, c_rsp, {pa[1], 4'h5, 1'b0});
        end
        tick();
        idle();
        #1;
        total++;
        if (c_rspValid !== 2'b00 || errBadTag !== 1'b1 || numOutstanding !== 5'd0) begin
            bad++; $display("FAIL bad_tag7 v=%b err=%b num=%0d want 00/1/0", c_rspValid, errBadTag, numOutstanding);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            idle(); c_lookupEn = 2'b01; c_pageVA[0] = rnd36(); c_tag[0] = 4'($urandom); tick();
        end
        idle();
        reset = 1'b1; c_lookupEn = 2'b11; s_lookupRdy = 1'b0;
        #1;
        total++;
        if (numOutstanding !== 5'd4 || c_lookupRdy !== 2'b00 || s_lookupEn !== 1'b0) begin
            bad++; $display("FAIL midrst_during num=%0d rdy=%b en=%b want 4/00/0", numOutstanding, c_lookupRdy, s_lookupEn);
        end
        tick();
        reset = 1'b0;
        idle();
        #1;
        total++;
        if (numOutstanding !== 5'd0 || s_lookupEn !== 1'b0 || errBadTag !== 1'b0) begin
            bad++; $display("FAIL midrst_after num=%0d en=%b err=%b want 0/0/0", numOutstanding, s_lookupEn, errBadTag);
        end
        tick();
        idle(); respond_tag(1, rnd36(), 1'b0); tick();
        idle();
        #1;
        total++;
        if (c_rspValid !== 2'b00 || errBadTag !== 1'b1) begin
            bad++; $display("FAIL midrst_stale_rsp v=%b err=%b want 00/1", c_rspValid, errBadTag);
        end
        tick();
    endtask

    task automatic test_random();
        int pct;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            idle();
            c_lookupEn = NC'($urandom);
            c_pageVA[0] = rnd36(); c_pageVA[1] = rnd36();
            c_tag[0] = 4'($urandom); c_tag[1] = 4'($urandom);
            s_lookupRdy = ($urandom_range(0, 3) != 0);
            pct = (cyc < 500) ? 20 : 70;
            if (srvIssued.size() > 0 && $urandom_range(0, 99) < pct) begin
                respond_tag(srvIssued[$urandom_range(0, srvIssued.size() - 1)], rnd36(), 1'($urandom));
            end
            tick();
        end
        drain();
    endtask

    initial begin
        reset = 1'b1;
        c_pageVA = '0;
        c_tag = '0;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_fairness();
        test_pool_full();
        test_server_stall();
        test_ooo_badtag();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
